// File: rtl/tdm_demux_1to4.sv
// Receive side of the 4:1 TDM link: frame lock, slot tracking and parallel word rebuild.
// Optional even-parity slot (5-beat frame) enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux_1to4 #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SLOT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    input  logic              in_valid,
    input  logic              frame_sync,
    output logic [NUM_CH-1:0] data_out,
    output logic              frame_valid,
    output logic [SLOT_W-1:0] sel_n,
    output logic              locked,
    output logic              sync_err,
    output logic              parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
    // All four data slots are buffered; the parity beat closes the frame.
    localparam int unsigned SHADOW_W = NUM_CH;
`else
    // Slot 3 goes straight to data_out, so only slots 0..2 are buffered.
    localparam int unsigned SHADOW_W = NUM_CH - 1;
`endif
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SHADOW_W);

    typedef enum logic [0:0] {StHunt, StLocked} state_t;

    state_t              state_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [SHADOW_W-1:0] shadow_q;
    logic [SHADOW_W-1:0] shadow_wr;
    logic [SHADOW_W-1:0] shadow_first;

    always_comb begin
        shadow_wr = shadow_q;
        for (int i = 0; i < int'(SHADOW_W); i++) begin
            if (slot_q == SLOT_W'(i)) begin
                shadow_wr[i] = data_in;
            end
        end
    end

    assign shadow_first = {{(SHADOW_W-1){1'b0}}, data_in};

`ifdef TDM_DEMUX_PARITY_EN
    logic parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            slot_q      <= '0;
            shadow_q    <= '0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (in_valid) begin
                case (state_q)
                    StHunt: begin
                        if (frame_sync) begin
                            shadow_q <= shadow_first;
                            slot_q   <= SLOT_W'(1);
                            state_q  <= StLocked;
                        end
                    end
                    StLocked: begin
                        if (frame_sync && (slot_q != '0)) begin
                            // Misplaced sync: drop the partial frame and restart at slot 0.
                            sync_err <= 1'b1;
                            shadow_q <= shadow_first;
                            slot_q   <= SLOT_W'(1);
                        end else if (slot_q == LAST_SLOT) begin
`ifdef TDM_DEMUX_PARITY_EN
                            if (^{shadow_q, data_in} == 1'b0) begin
                                data_out    <= shadow_q;
                                frame_valid <= 1'b1;
                            end else begin
                                parity_err_q <= 1'b1;
                            end
`else
                            data_out    <= {data_in, shadow_q};
                            frame_valid <= 1'b1;
`endif
                            slot_q <= '0;
                        end else begin
                            shadow_q <= shadow_wr;
                            slot_q   <= slot_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StHunt;
                        slot_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign sel_n  = slot_q;
    assign locked = (state_q == StLocked);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Self-checking bench for tdm_demux_1to4: directed test-plan steps plus random traffic
// checked against a queue-based frame model.
module tb_tdm_demux_1to4;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [3:0] data_out;
    logic       frame_valid;
    logic [2:0] sel_n;
    logic       locked;
    logic       sync_err;
    logic       parity_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: bits received so far in the current frame.
    bit         m_locked = 1'b0;
    int         m_q[$];
    logic [3:0] m_data = 4'b0000;
    logic       m_fv = 1'b0;
    logic       m_se = 1'b0;
    logic       m_pe = 1'b0;

    tdm_demux_1to4 dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .data_out   (data_out),
        .frame_valid(frame_valid),
        .sel_n      (sel_n),
        .locked     (locked),
        .sync_err   (sync_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic s, input logic d);
        int word;
        int par;
        m_fv = 1'b0;
        m_se = 1'b0;
        m_pe = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_q.delete();
            m_data = 4'b0000;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    m_q.delete();
                    m_q.push_back(int'(d));
                end
            end else if (s && m_q.size() != 0) begin
                m_se = 1'b1;
                m_q.delete();
                m_q.push_back(int'(d));
            end else begin
                m_q.push_back(int'(d));
                if (m_q.size() == FRAME_LEN) begin
                    word = 0;
                    par  = 0;
                    for (int i = 0; i < FRAME_LEN; i++) par ^= m_q[i];
                    for (int i = 0; i < 4; i++) word += m_q[i] << i;
                    if (FRAME_LEN == 5 && par != 0) begin
                        m_pe = 1'b1;
                    end else begin
                        m_data = 4'(word);
                        m_fv   = 1'b1;
                    end
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic d);
        @(negedge clk);
        rst        = r;
        in_valid   = v;
        frame_sync = s;
        data_in    = d;
        @(posedge clk);
        model(r, v, s, d);
        #1;
        chk("data_out", 8'(data_out), 8'(m_data));
        chk("frame_valid", 8'(frame_valid), 8'(m_fv));
        chk("sel_n", 8'(sel_n), 8'(m_q.size()));
        chk("locked", 8'(locked), 8'(m_locked));
        chk("sync_err", 8'(sync_err), 8'(m_se));
        chk("parity_err", 8'(parity_err), 8'(m_pe));
    endtask

    task automatic beat(input logic s, input logic d);
        step(1'b0, 1'b1, s, d);
    endtask

    // Idle cycle with junk on data/sync, which must be ignored.
    task automatic idle();
        step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic parity_beat(input logic [3:0] w);
        if (FRAME_LEN == 5) beat(1'b0, ^w);
    endtask

    initial begin
        logic [3:0] w;

        // Reset, then unsynced beats stay in hunt.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);

        // Lock and first frame 1101.
        w = 4'b1101;
        for (int i = 0; i < 4; i++) beat(i == 0, w[i]);
        parity_beat(w);
        chk("lock_frame_word", 8'(data_out), 8'h0d);

        // Frame 0110 with two idle cycles between beats 2 and 3, then 1001.
        w = 4'b0110;
        beat(1'b1, w[0]);
        beat(1'b0, w[1]);
        idle();
        idle();
        beat(1'b0, w[2]);
        beat(1'b0, w[3]);
        parity_beat(w);
        chk("gap_frame_word", 8'(data_out), 8'h06);
        w = 4'b1001;
        for (int i = 0; i < 4; i++) beat(i == 0, w[i]);
        parity_beat(w);

        // Misplaced sync on the third beat restarts the frame.
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        parity_beat(4'b1001);
        chk("resync_frame_word", 8'(data_out), 8'h09);

        // Sync on the final slot of a frame is also misplaced.
        for (int i = 0; i < FRAME_LEN - 1; i++) beat(i == 0, 1'b1);
        beat(1'b1, 1'b0);

        // Reset mid-frame, then unsynced beats must not produce a frame.
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < FRAME_LEN; i++) beat(1'b0, 1'b1);

`ifdef TDM_DEMUX_PARITY_EN
        // Good parity, then the same frame with bad parity.
        w = 4'b1101;
        for (int i = 0; i < 4; i++) beat(i == 0, w[i]);
        beat(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) beat(i == 0, w[i]);
        beat(1'b0, 1'b0);
`endif

        // Random traffic: mostly valid, occasional sync, rare reset.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
